// File: rtl/addsub_pkg.sv
// addsub_pkg
// Shared types for the round-robin add/subtract arbiter.
//   addsub_req_t : one requester's operands (a, b) and the sub select
//   addsub_rsp_t : the shared unit's result and carry/no-borrow flag
//   slot_state_e : occupancy of the single registered output slot
package addsub_pkg;

  localparam int WIDTH_DEF = 8;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
    logic                 sub;
  } addsub_req_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] result;
    logic                 flag;
  } addsub_rsp_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/addsub_unit.sv
// addsub_unit
// Purely combinational WIDTH-bit adder/subtractor shared by all requesters.
//   op_in   : operands a, b and sub (1 = a - b)
//   rsp_out : result and flag; flag is the carry-out for add and the
//             no-borrow indication (a >= b unsigned) for subtract
module addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  addsub_req_t op_in,
  output addsub_rsp_t rsp_out
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // Subtract is a + ~b + 1, so the carry-out naturally means "no borrow".
  always_comb begin
    b_eff          = op_in.sub ? ~op_in.b : op_in.b;
    sum            = {1'b0, op_in.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_in.sub};
    rsp_out.result = sum[WIDTH-1:0];
    rsp_out.flag   = sum[WIDTH];
  end

endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter
// Round-robin arbiter sharing one add/subtract unit between N_REQ requesters,
// with a single registered result slot.
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester request valid
//   req_ready  : per-requester accept, one-hot or zero
//   req_op     : per-requester operands
//   rsp_valid  : result slot holds a valid result
//   rsp_ready  : consumer takes the result
//   rsp_data   : registered result and flag
//   rsp_id     : index of the requester that produced rsp_data
//   op_count   : saturating count of accepted requests
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  input  addsub_req_t       req_op [N_REQ],
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output addsub_rsp_t       rsp_data,
  output logic [ID_W-1:0]   rsp_id,
  output logic [CNT_W-1:0]  op_count
);

  slot_state_e       state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  addsub_rsp_t       rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic              slot_free;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic              accept;
  addsub_req_t       unit_in;
  addsub_rsp_t       unit_out;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!grant_found && req_valid[(int'(ptr_q) + i) % N_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  // The slot can take a new result if empty or if it is being drained now.
  // rst gating keeps req_ready low for the whole reset window.
  always_comb begin
    slot_free = (state_q == SLOT_EMPTY) | rsp_ready;
    accept    = grant_found & slot_free & ~rst;
    req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;
    unit_in   = req_op[grant_idx];
  end

  addsub_unit #(
    .WIDTH (WIDTH)
  ) u_unit (
    .op_in   (unit_in),
    .rsp_out (unit_out)
  );

  // Slot FSM and datapath capture. The pointer only moves on an accept, so a
  // stalled slot does not burn anyone's priority.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    op_count_d = op_count_q;

    if (accept) begin
      state_d    = SLOT_FULL;
      ptr_d      = grant_idx;
      rsp_data_d = unit_out;
      rsp_id_d   = grant_idx;
      if (op_count_q != {CNT_W{1'b1}}) begin
        op_count_d = op_count_q + CNT_W'(1);
      end
    end else if ((state_q == SLOT_FULL) && rsp_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SLOT_EMPTY;
      ptr_q      <= ID_W'(N_REQ - 1);
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      op_count_q <= op_count_d;
    end
  end

  assign rsp_valid = (state_q == SLOT_FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;

endmodule
